seven_seg_scan_driver: RTL and testbench
========================================

// Module: seven_seg_scan_driver
//
// PURPOSE
//  Time-multiplexed driver for a common-anode, multi-digit seven-segment display.
//  It captures a p_num_digits*4-bit value and scans one digit per refresh period.
//  Each nibble is decoded as hex 0-F, with optional leading-zero blanking and
//  per-digit decimal points. It sits between datapath result registers and the
//  board display pins, and supersedes per-digit combinational decoders.
//
// PARAMETERS
//  p_num_digits      4     digits driven; legal range 1..8
//  p_refresh_cycles  1000  clk cycles each digit stays lit; must be >= 2
//
// PORTS
//  clk      in   1                 clock
//  rst      in   1                 synchronous, active-high reset
//  en       in   1                 1 = scan; 0 = display dark, prescaler and index frozen
//  load     in   1                 capture in/dp into the shadow register this cycle
//  in       in   p_num_digits*4    value; digit i is in[4i+3:4i], digit 0 is least significant
//  dp       in   p_num_digits      decimal point request per digit (1 = lit)
//  blank_lz in   1                 1 = blank leading zero digits
//  an       out  p_num_digits      anode select, one-hot active-low
//  seg      out  7                 segments, active-low; seg[0]=a .. seg[6]=g
//  dp_out   out  1                 decimal point, active-low
//
// BEHAVIOUR
//  - Reset (rst=1 at a posedge): an='1, seg=7'h7F, dp_out=1. Prescaler=0, digit index=0,
//    shadow=0, display=0, pending=0. rst wins over load and en in the same cycle.
//  - Prescaler: counts 0..p_refresh_cycles-1 while en=1. At terminal count it wraps to 0
//    and the digit index advances from p_num_digits-1 back to 0.
//  - Outputs are registered. On every posedge with en=1, an/seg/dp_out reflect the
//    current index, using the display register. Latency from an index change to the pins
//    is 1 cycle. First posedge after reset with en=1: an[0]=0 and seg shows digit 0.
//  - Load: on load=1, shadow <= {dp,in} and pending <= 1. Back-to-back loads overwrite
//    the shadow; the last one wins.
//  - Commit: display <= shadow and pending <= 0 only on the cycle the index wraps to 0,
//    so a frame never shows a mix of old and new digits. With en=0, a pending load
//    commits on the next cycle.
//  - Digit encoding: hex 0-F in standard patterns (0=7'h40, 1=7'h79, 8=7'h00, F=7'h0E).
//  - Leading-zero blanking: digit i>0 is blanked when blank_lz=1 and nibbles i..N-1 are
//    all zero. Digit 0 is never blanked. A blanked digit keeps its anode timing but
//    drives seg=7'h7F and dp_out=1.
//  - en=0: an='1, seg=7'h7F, dp_out=1 from the next posedge; prescaler and index hold.
//    Re-enabling resumes the same digit with the remaining count.
//  - p_num_digits=1: the index is constant 0 and the commit happens at prescaler wrap.
//  - an is never multi-hot on any cycle.
//
// STRUCTURE
//  - Package seven_seg_pkg:
//    - SEG_BLANK=7'h7F.
//    - Hex glyph constant table.
//    - typedef seg_t (logic [6:0]).
//  - Sub-module hex_to_seven_seg: combinational 4-bit -> seg_t decoder, instanced once
//    on the muxed nibble.
//  - Prescaler width: $clog2(p_refresh_cycles). Index width: max(1,$clog2(p_num_digits)).
//
// TESTING  (p_num_digits=4, p_refresh_cycles=4 unless noted)
//  1. rst held 3 cycles, then en=1
//     -> an=4'b1111, seg=7'h7F during reset
//     -> an=4'b1110, seg=7'h40 on the first posedge after release.
//  2. load in=16'h12AF, blank_lz=0
//     -> after the next wrap, each 4-cycle slot shows:
//        an=1110 seg=7'h0E; an=1101 seg=7'h08; an=1011 seg=7'h24; an=0111 seg=7'h79.
//  3. Load 16'h0000 then 16'h0042 mid-frame
//     -> the current frame is unchanged
//     -> the next frame shows 16'h0042 (last load wins).
//  4. blank_lz=1, in=16'h0040
//     -> digits 3 and 2 give seg=7'h7F, digit 1 is "4", digit 0 is "0".
//     -> in=16'h0000 shows only digit 0 "0".
//  5. dp=4'b0100
//     -> dp_out=0 only while an=1011.
//  6. en=0 mid-slot for 5 cycles
//     -> dark outputs; after en=1, the same digit finishes its remaining cycles.
//  7. rst during a scan with pending=1
//     -> the pending load is discarded and the display shows 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment vectors are active-low: seg[0]=a .. seg[6]=g.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  // All segments off
  localparam seg_t SEG_BLANK = 7'h7F;

  // Hex glyphs 0..F, active-low
  localparam seg_t HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational hex nibble to active-low segment decoder.
// Ports:
//   nibble  in   4  hex digit value
//   seg_c   out  7  active-low segment pattern (a = bit 0)
module hex_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg_c
);

  assign seg_c = HEX_GLYPH[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed driver for a common-anode multi-digit seven-segment display.
// A shadow register captures new values at any time; they are moved into the
// display register only at a frame boundary so a frame never mixes values.
// Ports:
//   clk       in   1      clock
//   rst       in   1      synchronous active-high reset
//   en        in   1      scan enable; 0 = dark outputs, counters frozen
//   load      in   1      capture in/dp into the shadow register
//   in        in   N*4    value, digit 0 in the low nibble
//   dp        in   N      decimal point request per digit
//   blank_lz  in   1      blank leading zero digits
//   an        out  N      anode select, one-hot active-low
//   seg       out  7      segments, active-low
//   dp_out    out  1      decimal point, active-low
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned p_num_digits     = 4,
  parameter int unsigned p_refresh_cycles = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      load,
  input  logic [p_num_digits*4-1:0] in,
  input  logic [p_num_digits-1:0]   dp,
  input  logic                      blank_lz,
  output logic [p_num_digits-1:0]   an,
  output seg_t                      seg,
  output logic                      dp_out
);

  localparam int unsigned VAL_W = p_num_digits * 4;
  localparam int unsigned PRE_W = $clog2(p_refresh_cycles);
  localparam int unsigned IDX_W = (p_num_digits > 1) ? $clog2(p_num_digits) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(p_refresh_cycles - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(p_num_digits - 1);
  localparam logic [p_num_digits-1:0] AN_OFF = '1;

  logic [PRE_W-1:0]        prescaler;
  logic [IDX_W-1:0]        idx;
  logic [VAL_W-1:0]        shadow_val;
  logic [p_num_digits-1:0] shadow_dp;
  logic [VAL_W-1:0]        disp_val;
  logic [p_num_digits-1:0] disp_dp;
  logic                    pending;

  logic       slot_end_c;
  logic       frame_end_c;
  logic       commit_c;
  logic [3:0] nibble_c;
  logic       dp_sel_c;
  logic       zero_run_c;
  logic       upper_zero_c;
  logic       blank_c;
  seg_t       glyph_c;

  // Slot and frame boundaries, and when the shadow moves to the display
  always_comb begin
    slot_end_c  = en && (prescaler == PRE_LAST);
    frame_end_c = slot_end_c && (idx == IDX_LAST);
    commit_c    = pending && (frame_end_c || !en);
  end

  // Select the current digit and decide whether it is a leading zero.
  // Walking from the top digit down, zero_run_c stays set only while every
  // nibble seen so far is zero.
  always_comb begin
    nibble_c     = 4'h0;
    dp_sel_c     = 1'b0;
    zero_run_c   = 1'b1;
    upper_zero_c = 1'b0;
    for (int i = int'(p_num_digits) - 1; i >= 0; i--) begin
      zero_run_c = zero_run_c && (disp_val[4*i +: 4] == 4'h0);
      if (IDX_W'(i) == idx) begin
        nibble_c     = disp_val[4*i +: 4];
        dp_sel_c     = disp_dp[i];
        upper_zero_c = zero_run_c;
      end
    end
    blank_c = blank_lz && (idx != '0) && upper_zero_c;
  end

  hex_to_seven_seg u_hex_to_seven_seg (
    .nibble (nibble_c),
    .seg_c  (glyph_c)
  );

  // Scan counters, shadow/display registers and registered pin drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler  <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp_out     <= 1'b1;
    end else begin
      if (en) begin
        if (slot_end_c) begin
          prescaler <= '0;
          idx       <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
          prescaler <= prescaler + PRE_W'(1);
        end
        an     <= ~(p_num_digits'(1) << idx);
        seg    <= blank_c ? SEG_BLANK : glyph_c;
        dp_out <= ~(dp_sel_c && !blank_c);
      end else begin
        an     <= AN_OFF;
        seg    <= SEG_BLANK;
        dp_out <= 1'b1;
      end

      if (load) begin
        shadow_val <= in;
        shadow_dp  <= dp;
      end

      // A load coinciding with a commit stays pending for the next frame
      if (commit_c) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
      end

      pending <= load || (pending && !commit_c);
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (4 digits, 4-cycle refresh).
module tb_seven_seg_scan_driver;

  localparam int N = 4;
  localparam int R = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   in = '0;
  logic [3:0]    dp = '0;
  logic          blank_lz = 1'b0;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp_out;

  int n_cmp = 0;
  int n_err = 0;

  seven_seg_scan_driver #(.p_num_digits(N), .p_refresh_cycles(R)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .in       (in),
    .dp       (dp),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp_out   (dp_out)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Reference model: scan position as plain counters, value as a 16-bit word
  int          m_pre = 0;
  int          m_idx = 0;
  logic [15:0] m_sh = '0, m_disp = '0, m_shown = '0;
  logic [3:0]  m_shdp = '0, m_dispdp = '0, m_showndp = '0;
  bit          m_pend = 0;
  bit          m_lit = 0;
  logic [3:0]  m_an = 4'hF;
  logic [6:0]  m_seg = 7'h7F;
  logic        m_dp = 1'b1;

  always @(posedge clk) begin
    bit frame_done, commit, new_pend, blank;
    int nib;
    if (rst) begin
      m_pre = 0; m_idx = 0; m_sh = '0; m_shdp = '0; m_disp = '0; m_dispdp = '0;
      m_pend = 0; m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1; m_lit = 0;
    end else begin
      frame_done = 0;
      m_shown = m_disp;
      m_showndp = m_dispdp;
      m_lit = en;
      if (en) begin
        nib = int'((m_disp >> (4 * m_idx)) & 16'hF);
        // digit is a leading zero when it and everything above it are zero
        blank = blank_lz && (m_idx > 0) && ((m_disp >> (4 * m_idx)) == 16'h0);
        m_an = 4'hF & ~(4'(1) << m_idx);
        m_seg = blank ? 7'h7F : glyph[nib];
        m_dp = blank || !m_dispdp[m_idx];
        frame_done = (m_pre == R - 1) && (m_idx == N - 1);
        m_pre = (m_pre + 1) % R;
        if (m_pre == 0) m_idx = (m_idx + 1) % N;
      end else begin
        m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
      end
      commit = m_pend && (frame_done || !en);
      new_pend = load || (m_pend && !commit);
      if (commit) begin m_disp = m_sh; m_dispdp = m_shdp; end
      if (load) begin m_sh = in; m_shdp = dp; end
      m_pend = new_pend;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({an, seg, dp_out} !== {4'b1111, 7'h7F, 1'b1}) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d: an=%b seg=%h dp=%b, want an=1111 seg=7f dp=1", c, an, seg, dp_out);
      end
    end
    rst = 1'b0; en = 1'b1;
    tick();
    n_cmp++;
    if ({an, seg, dp_out} !== {4'b1110, 7'h40, 1'b1}) begin
      n_err++;
      $display("FAIL reset_first_digit: an=%b seg=%h dp=%b, want an=1110 seg=40 dp=1", an, seg, dp_out);
    end
  endtask

  task automatic test_scan_pattern();
    logic [6:0] exp;
    in = 16'h12AF; dp = 4'b0000; blank_lz = 1'b0; load = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      load = 1'b0;
      n_cmp++;
      if ({an, seg, dp_out} !== {m_an, m_seg, m_dp}) begin
        n_err++;
        $display("FAIL scan_model cyc=%0d: an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b", c, an, seg, dp_out, m_an, m_seg, m_dp);
      end
      if (m_lit && m_shown == 16'h12AF) begin
        case (m_an)
          4'b1110: exp = 7'h0E;
          4'b1101: exp = 7'h08;
          4'b1011: exp = 7'h24;
          default: exp = 7'h79;
        endcase
        n_cmp++;
        if (seg !== exp) begin
          n_err++;
          $display("FAIL scan_12af an=%b: seg=%h, want %h", m_an, seg, exp);
        end
      end
    end
  endtask

  task automatic test_last_load_wins();
    logic [6:0] exp;
    tick();
    in = 16'h0000; load = 1'b1;
    tick();
    in = 16'h0042;
    tick();
    load = 1'b0;
    for (int c = 0; c < 36; c++) begin
      n_cmp++;
      if ({an, seg, dp_out} !== {m_an, m_seg, m_dp}) begin
        n_err++;
        $display("FAIL lastload_model cyc=%0d: an=%b seg=%h, want an=%b seg=%h", c, an, seg, m_an, m_seg);
      end
      n_cmp++;
      if (m_shown != 16'h12AF && m_shown != 16'h0042) begin
        n_err++;
        $display("FAIL lastload_intermediate cyc=%0d: shown=%h, want 12af or 0042", c, m_shown);
      end
      if (m_lit && m_shown == 16'h0042) begin
        case (m_an)
          4'b1110: exp = 7'h24;
          4'b1101: exp = 7'h19;
          default: exp = 7'h40;
        endcase
        n_cmp++;
        if (seg !== exp) begin
          n_err++;
          $display("FAIL lastload_0042 an=%b: seg=%h, want %h", m_an, seg, exp);
        end
      end
      tick();
    end
  endtask

  task automatic test_blanking();
    logic [6:0] exp;
    blank_lz = 1'b1;
    for (int v = 0; v < 2; v++) begin
      in = (v == 0) ? 16'h0040 : 16'h0000;
      load = 1'b1;
      for (int c = 0; c < 36; c++) begin
        tick();
        load = 1'b0;
        n_cmp++;
        if ({an, seg, dp_out} !== {m_an, m_seg, m_dp}) begin
          n_err++;
          $display("FAIL blank_model v=%0d cyc=%0d: an=%b seg=%h, want an=%b seg=%h", v, c, an, seg, m_an, m_seg);
        end
        if (m_lit && m_shown == in) begin
          case (m_an)
            4'b1110: exp = 7'h40;
            4'b1101: exp = (v == 0) ? 7'h19 : 7'h7F;
            default: exp = 7'h7F;
          endcase
          n_cmp++;
          if (seg !== exp) begin
            n_err++;
            $display("FAIL blank_lit v=%0d an=%b: seg=%h, want %h", v, m_an, seg, exp);
          end
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_dp();
    in = 16'h1234; dp = 4'b0100; load = 1'b1;
    for (int c = 0; c < 36; c++) begin
      tick();
      load = 1'b0;
      n_cmp++;
      if ({an, seg, dp_out} !== {m_an, m_seg, m_dp}) begin
        n_err++;
        $display("FAIL dp_model cyc=%0d: an=%b dp=%b, want an=%b dp=%b", c, an, dp_out, m_an, m_dp);
      end
      if (m_lit && m_showndp == 4'b0100) begin
        n_cmp++;
        if (dp_out !== (m_an != 4'b1011)) begin
          n_err++;
          $display("FAIL dp_lit an=%b: dp_out=%b, want %b", m_an, dp_out, m_an != 4'b1011);
        end
      end
    end
    dp = 4'b0000;
  endtask

  task automatic test_enable_pause();
    int p0, i0;
    logic [3:0] exp_an;
    // advance into the middle of a slot
    do tick(); while (m_pre != 1);
    p0 = m_pre; i0 = m_idx;
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if ({an, seg, dp_out} !== {4'b1111, 7'h7F, 1'b1}) begin
        n_err++;
        $display("FAIL pause_dark cyc=%0d: an=%b seg=%h dp=%b, want 1111 7f 1", c, an, seg, dp_out);
      end
    end
    en = 1'b1;
    exp_an = 4'hF & ~(4'(1) << i0);
    for (int c = 0; c < R - p0 + 1; c++) begin
      tick();
      n_cmp++;
      if ((an === exp_an) !== (c < R - p0)) begin
        n_err++;
        $display("FAIL resume_slot cyc=%0d: an=%b, want %s %b", c, an, (c < R - p0) ? "equal" : "not", exp_an);
      end
      n_cmp++;
      if ({an, seg, dp_out} !== {m_an, m_seg, m_dp}) begin
        n_err++;
        $display("FAIL resume_model cyc=%0d: an=%b seg=%h, want an=%b seg=%h", c, an, seg, m_an, m_seg);
      end
    end
  endtask

  task automatic test_reset_pending();
    in = 16'h5555; dp = 4'b1111; load = 1'b1;
    tick();
    load = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; dp = 4'b0000;
    for (int c = 0; c < 2 * N * R; c++) begin
      tick();
      n_cmp++;
      if ({an, seg, dp_out} !== {4'hF & ~(4'(1) << ((c / R) % N)), 7'h40, 1'b1}) begin
        n_err++;
        $display("FAIL rst_pending cyc=%0d: an=%b seg=%h dp=%b, want an=%b seg=40 dp=1", c, an, seg, dp_out, 4'hF & ~(4'(1) << ((c / R) % N)));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom % 150) == 0;
      en = ($urandom % 8) != 0;
      load = ($urandom % 6) == 0;
      in = ($urandom % 3 == 0) ? 16'($urandom % 256) : 16'($urandom);
      dp = 4'($urandom);
      blank_lz = 1'($urandom);
      tick();
      n_cmp++;
      if ({an, seg, dp_out} !== {m_an, m_seg, m_dp} || $countones(~an) > 1) begin
        n_err++;
        $display("FAIL random cyc=%0d: an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b", c, an, seg, dp_out, m_an, m_seg, m_dp);
      end
    end
    rst = 1'b0; load = 1'b0; en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan_pattern();
    test_last_load_wins();
    test_blanking();
    test_dp();
    test_enable_pause();
    test_reset_pending();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
